// File: rtl/iob_eth_rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : iob_eth_rx_frame_ctrl_if
//  Purpose  : Groups the receiver byte-stream strobes, the CPU acknowledge
//             request and the frame-status outputs of iob_eth_rx_frame_ctrl.
//  Ports    : master - receiver/CPU side (drives strobes, reads status)
//             slave  - frame controller side
//  Revision : 1.0 - initial release
// ============================================================================
interface iob_eth_rx_frame_ctrl_if #(
    parameter int BUFFER_W = 11,
    parameter int CNT_W    = 16
);
    logic                rx_sof_i;
    logic                rx_byte_valid_i;
    logic                rx_eof_i;
    logic                rx_crc_err_i;
    logic                rcv_ack_req_i;
    logic                rx_en_o;
    logic                rx_data_rcvd_o;
    logic [BUFFER_W-1:0] rx_nbytes_o;
    logic                rcv_ack_o;
    logic [CNT_W-1:0]    crc_err_cnt_o;
    logic [CNT_W-1:0]    drop_cnt_o;

    modport master (
        output rx_sof_i, rx_byte_valid_i, rx_eof_i, rx_crc_err_i, rcv_ack_req_i,
        input  rx_en_o, rx_data_rcvd_o, rx_nbytes_o, rcv_ack_o,
               crc_err_cnt_o, drop_cnt_o
    );

    modport slave (
        input  rx_sof_i, rx_byte_valid_i, rx_eof_i, rx_crc_err_i, rcv_ack_req_i,
        output rx_en_o, rx_data_rcvd_o, rx_nbytes_o, rcv_ack_o,
               crc_err_cnt_o, drop_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/iob_eth_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : iob_eth_rx_frame_ctrl
//  Purpose  : Tracks one received Ethernet frame, counts its bytes, publishes
//             good frames to the CSR side and runs a timed CPU acknowledge.
//  Ports    : clk_i     - clock
//             cke_i     - clock enable, all state holds while low
//             arst_n_i  - asynchronous active-low reset
//             bus       - slave modport: receiver strobes, ack request,
//                         rx_en/rcvd/nbytes/ack status, error/drop counters
//  Revision : 1.0 - initial release
// ============================================================================
module iob_eth_rx_frame_ctrl #(
    parameter int BUFFER_W   = 11,
    parameter int MIN_BYTES  = 64,
    parameter int ACK_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     arst_n_i,
    iob_eth_rx_frame_ctrl_if.slave   bus
);

    localparam logic [1:0]          c_ST_IDLE  = 2'd0;
    localparam logic [1:0]          c_ST_RECV  = 2'd1;
    localparam logic [1:0]          c_ST_PEND  = 2'd2;
    localparam logic [1:0]          c_ST_ACK   = 2'd3;
    localparam logic [BUFFER_W-1:0] c_BYTE_MAX = '1;
    localparam logic [CNT_W-1:0]    c_CNT_MAX  = '1;
    localparam logic [3:0]          c_ACK_LOAD = 4'(ACK_CYCLES);

    logic [1:0]          state_q,    state_d;
    logic [BUFFER_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [BUFFER_W-1:0] nbytes_q,   nbytes_d;
    logic                ovf_q,      ovf_d;
    logic [3:0]          ack_cnt_q,  ack_cnt_d;
    logic [CNT_W-1:0]    crc_cnt_q,  crc_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic                w_crc_inc;
    logic                w_drop_inc;
    logic [BUFFER_W-1:0] w_final_cnt;
    logic                w_final_ovf;
    logic [BUFFER_W-1:0] w_load_cnt;

    // Count including a byte that arrives in the same cycle as eof; the
    // counter saturates and a byte beyond the maximum marks the frame oversize.
    always_comb begin
        w_final_ovf = ovf_q | (bus.rx_byte_valid_i & (byte_cnt_q == c_BYTE_MAX));
        w_final_cnt = byte_cnt_q;
        if (bus.rx_byte_valid_i && (byte_cnt_q != c_BYTE_MAX)) begin
            w_final_cnt = byte_cnt_q + 1'b1;
        end
        w_load_cnt = BUFFER_W'(bus.rx_byte_valid_i);
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        nbytes_d   = nbytes_q;
        ovf_d      = ovf_q;
        ack_cnt_d  = ack_cnt_q;
        w_crc_inc  = 1'b0;
        w_drop_inc = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (bus.rx_sof_i) begin
                    byte_cnt_d = w_load_cnt;
                    ovf_d      = 1'b0;
                    state_d    = c_ST_RECV;
                end
            end
            c_ST_RECV: begin
                byte_cnt_d = w_final_cnt;
                ovf_d      = w_final_ovf;
                // eof wins over a simultaneous sof
                if (bus.rx_eof_i) begin
                    byte_cnt_d = '0;
                    ovf_d      = 1'b0;
                    state_d    = c_ST_IDLE;
                    if (bus.rx_crc_err_i || (int'(w_final_cnt) < MIN_BYTES)) begin
                        w_crc_inc = 1'b1;
                    end else if (w_final_ovf) begin
                        w_drop_inc = 1'b1;
                    end else begin
                        nbytes_d = w_final_cnt;
                        state_d  = c_ST_PEND;
                    end
                end else if (bus.rx_sof_i) begin
                    // Restart: the abandoned frame is a drop
                    w_drop_inc = 1'b1;
                    byte_cnt_d = w_load_cnt;
                    ovf_d      = 1'b0;
                end
            end
            c_ST_PEND: begin
                // Buffer still owned by the CPU: any new frame is lost
                w_drop_inc = bus.rx_sof_i;
                if (bus.rcv_ack_req_i) begin
                    ack_cnt_d = c_ACK_LOAD;
                    state_d   = c_ST_ACK;
                end
            end
            default: begin
                w_drop_inc = bus.rx_sof_i;
                if (ack_cnt_q <= 4'd1) begin
                    ack_cnt_d = '0;
                    nbytes_d  = '0;
                    state_d   = c_ST_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q - 1'b1;
                end
            end
        endcase

        crc_cnt_d  = crc_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (w_crc_inc && (crc_cnt_q != c_CNT_MAX)) begin
            crc_cnt_d = crc_cnt_q + 1'b1;
        end
        if (w_drop_inc && (drop_cnt_q != c_CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= c_ST_IDLE;
            byte_cnt_q <= '0;
            nbytes_q   <= '0;
            ovf_q      <= 1'b0;
            ack_cnt_q  <= '0;
            crc_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else if (cke_i) begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            nbytes_q   <= nbytes_d;
            ovf_q      <= ovf_d;
            ack_cnt_q  <= ack_cnt_d;
            crc_cnt_q  <= crc_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // All outputs are decoded from registered state only
    assign bus.rx_en_o        = (state_q == c_ST_IDLE) || (state_q == c_ST_RECV);
    assign bus.rx_data_rcvd_o = (state_q == c_ST_PEND) || (state_q == c_ST_ACK);
    assign bus.rcv_ack_o      = (state_q == c_ST_ACK);
    assign bus.rx_nbytes_o    = nbytes_q;
    assign bus.crc_err_cnt_o  = crc_cnt_q;
    assign bus.drop_cnt_o     = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_eth_rx_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_iob_eth_rx_frame_ctrl
//  Purpose  : Self-checking bench for iob_eth_rx_frame_ctrl. Instance A uses
//             default parameters; instance B (BUFFER_W=7, CNT_W=2) covers
//             oversize frames and counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iob_eth_rx_frame_ctrl;
    localparam int BW  = 11;
    localparam int CW  = 16;
    localparam int BWB = 7;
    localparam int CWB = 2;

    logic clk    = 1'b0;
    logic cke    = 1'b1;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    iob_eth_rx_frame_ctrl_if #(.BUFFER_W(BW),  .CNT_W(CW))  ifa ();
    iob_eth_rx_frame_ctrl_if #(.BUFFER_W(BWB), .CNT_W(CWB)) ifb ();

    iob_eth_rx_frame_ctrl #(.BUFFER_W(BW), .MIN_BYTES(64), .ACK_CYCLES(4), .CNT_W(CW)) dut_a (
        .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .bus(ifa.slave)
    );
    iob_eth_rx_frame_ctrl #(.BUFFER_W(BWB), .MIN_BYTES(64), .ACK_CYCLES(4), .CNT_W(CWB)) dut_b (
        .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .bus(ifb.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int exp_crc  = 0;
    int exp_drop = 0;
    logic rcvd_prev = 1'b0;

    // Scoreboard: every rising rx_data_rcvd_o on A must match the next queued frame length
    always @(negedge clk) begin
        int e;
        if (arst_n && ifa.rx_data_rcvd_o && !rcvd_prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_frame: got frame of %0d bytes, required none", ifa.rx_nbytes_o);
            end else begin
                e = exp_q.pop_front();
                if (ifa.rx_nbytes_o !== e[BW-1:0]) begin
                    n_err++;
                    $display("FAIL sb_nbytes: got %0d, required %0d", ifa.rx_nbytes_o, e);
                end
            end
        end
        rcvd_prev = ifa.rx_data_rcvd_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit b, input bit sof, input bit vld, input bit eof, input bit crc);
        if (b) begin
            ifb.rx_sof_i = sof; ifb.rx_byte_valid_i = vld; ifb.rx_eof_i = eof; ifb.rx_crc_err_i = crc;
        end else begin
            ifa.rx_sof_i = sof; ifa.rx_byte_valid_i = vld; ifa.rx_eof_i = eof; ifa.rx_crc_err_i = crc;
        end
    endtask

    // sof cycle (no byte), n byte cycles, eof cycle; optionally last byte rides with eof
    task automatic drive_frame(input bit b, input int n, input bit crc, input bit last_with_eof);
        set_in(b, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < n - int'(last_with_eof); i++) begin
            set_in(b, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        set_in(b, 1'b0, last_with_eof, 1'b1, crc);
        tick();
        set_in(b, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_ack(output int cycles, output bit held);
        cycles = 0;
        held   = 1'b1;
        ifa.rcv_ack_req_i = 1'b1;
        tick();
        ifa.rcv_ack_req_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ifa.rcv_ack_o !== 1'b1) break;
            cycles++;
            if (ifa.rx_data_rcvd_o !== 1'b1) held = 1'b0;
            ifa.rcv_ack_req_i = (cycles == 2);   // a second request mid-ACK must be ignored
            tick();
        end
        ifa.rcv_ack_req_i = 1'b0;
    endtask

    task automatic check_idle_a(input string tag);
        n_cmp++;
        if (ifa.rx_data_rcvd_o !== 1'b0 || ifa.rx_nbytes_o !== '0 || ifa.rx_en_o !== 1'b1 || ifa.rcv_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got rcvd=%b nbytes=%0d en=%b ack=%b, required rcvd=0 nbytes=0 en=1 ack=0",
                     tag, ifa.rx_data_rcvd_o, ifa.rx_nbytes_o, ifa.rx_en_o, ifa.rcv_ack_o);
        end
    endtask

    task automatic check_cnts_a(input string tag);
        n_cmp++;
        if (ifa.crc_err_cnt_o !== CW'(exp_crc) || ifa.drop_cnt_o !== CW'(exp_drop)) begin
            n_err++;
            $display("FAIL %s: got crc=%0d drop=%0d, required crc=%0d drop=%0d",
                     tag, ifa.crc_err_cnt_o, ifa.drop_cnt_o, exp_crc, exp_drop);
        end
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ifa.rcv_ack_req_i = 1'b0;
        ifb.rcv_ack_req_i = 1'b0;
        arst_n = 1'b0;
        tick(); tick();
        check_idle_a("reset_outputs");
        check_cnts_a("reset_counters");
        arst_n = 1'b1;
        tick();
        check_idle_a("after_reset_release");
    endtask

    task automatic test_good_frame();
        exp_q.push_back(100);
        drive_frame(1'b0, 100, 1'b0, 1'b0);
        n_cmp++;
        if (ifa.rx_data_rcvd_o !== 1'b1 || ifa.rx_en_o !== 1'b0 || ifa.rx_nbytes_o !== 11'd100) begin
            n_err++;
            $display("FAIL good_frame_pend: got rcvd=%b en=%b nbytes=%0d, required rcvd=1 en=0 nbytes=100",
                     ifa.rx_data_rcvd_o, ifa.rx_en_o, ifa.rx_nbytes_o);
        end
        check_cnts_a("good_frame_counters");
    endtask

    task automatic test_ack(input string tag);
        int  cyc;
        bit  held;
        do_ack(cyc, held);
        n_cmp++;
        if (cyc != 4 || !held) begin
            n_err++;
            $display("FAIL %s_cycles: got %0d ack cycles held=%b, required 4 held=1", tag, cyc, held);
        end
        check_idle_a({tag, "_idle"});
    endtask

    task automatic test_ack_ignored_idle();
        ifa.rcv_ack_req_i = 1'b1;
        tick();
        ifa.rcv_ack_req_i = 1'b0;
        tick();
        check_idle_a("ack_req_in_idle");
    endtask

    task automatic test_errors();
        drive_frame(1'b0, 80, 1'b1, 1'b0);
        exp_crc++;
        tick();
        check_cnts_a("crc_err_frame");
        check_idle_a("crc_err_no_rcvd");
        drive_frame(1'b0, 63, 1'b0, 1'b0);
        exp_crc++;
        tick();
        check_cnts_a("runt_frame");
        check_idle_a("runt_no_rcvd");
    endtask

    task automatic test_busy_drop();
        exp_q.push_back(100);
        drive_frame(1'b0, 100, 1'b0, 1'b0);
        drive_frame(1'b0, 50, 1'b0, 1'b0);   // arrives while PEND
        exp_drop++;
        check_cnts_a("busy_drop_counters");
        n_cmp++;
        if (ifa.rx_data_rcvd_o !== 1'b1 || ifa.rx_nbytes_o !== 11'd100) begin
            n_err++;
            $display("FAIL busy_drop_hold: got rcvd=%b nbytes=%0d, required rcvd=1 nbytes=100",
                     ifa.rx_data_rcvd_o, ifa.rx_nbytes_o);
        end
        test_ack("busy_ack");
    endtask

    task automatic test_boundary64();
        exp_q.push_back(64);
        drive_frame(1'b0, 64, 1'b0, 1'b1);
        n_cmp++;
        if (ifa.rx_data_rcvd_o !== 1'b1 || ifa.rx_nbytes_o !== 11'd64) begin
            n_err++;
            $display("FAIL boundary64: got rcvd=%b nbytes=%0d, required rcvd=1 nbytes=64",
                     ifa.rx_data_rcvd_o, ifa.rx_nbytes_o);
        end
        test_ack("b64_ack");
    endtask

    // Restart mid-frame, then eof coinciding with a sof
    task automatic test_restart();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 30; i++) begin set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick(); end
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);   // restart carrying first byte
        tick();
        exp_drop++;
        for (int i = 0; i < 69; i++) begin set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick(); end
        exp_q.push_back(70);
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);   // eof wins, sof ignored
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cnts_a("restart_counters");
        n_cmp++;
        if (ifa.rx_data_rcvd_o !== 1'b1 || ifa.rx_nbytes_o !== 11'd70) begin
            n_err++;
            $display("FAIL restart_frame: got rcvd=%b nbytes=%0d, required rcvd=1 nbytes=70",
                     ifa.rx_data_rcvd_o, ifa.rx_nbytes_o);
        end
    endtask

    // With cke low an ack request is lost; frame stays pending
    task automatic test_cke();
        cke = 1'b0;
        ifa.rcv_ack_req_i = 1'b1;
        tick();
        ifa.rcv_ack_req_i = 1'b0;
        cke = 1'b1;
        tick();
        n_cmp++;
        if (ifa.rcv_ack_o !== 1'b0 || ifa.rx_data_rcvd_o !== 1'b1) begin
            n_err++;
            $display("FAIL cke_freeze: got ack=%b rcvd=%b, required ack=0 rcvd=1", ifa.rcv_ack_o, ifa.rx_data_rcvd_o);
        end
        test_ack("cke_ack");
    endtask

    task automatic test_oversize_saturate();
        drive_frame(1'b1, 130, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (ifb.drop_cnt_o !== 2'd1 || ifb.crc_err_cnt_o !== 2'd0 || ifb.rx_data_rcvd_o !== 1'b0) begin
            n_err++;
            $display("FAIL oversize_drop: got drop=%0d crc=%0d rcvd=%b, required drop=1 crc=0 rcvd=0",
                     ifb.drop_cnt_o, ifb.crc_err_cnt_o, ifb.rx_data_rcvd_o);
        end
        for (int i = 0; i < 3; i++) drive_frame(1'b1, 10, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (ifb.crc_err_cnt_o !== 2'd3) begin
            n_err++;
            $display("FAIL sat_reach: got crc=%0d, required 3", ifb.crc_err_cnt_o);
        end
        for (int i = 0; i < 2; i++) drive_frame(1'b1, 10, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (ifb.crc_err_cnt_o !== 2'd3) begin
            n_err++;
            $display("FAIL sat_hold: got crc=%0d, required 3 (no wrap)", ifb.crc_err_cnt_o);
        end
    endtask

    task automatic test_reset_mid_ack();
        exp_q.push_back(70);
        drive_frame(1'b0, 70, 1'b0, 1'b0);
        ifa.rcv_ack_req_i = 1'b1;
        tick();
        ifa.rcv_ack_req_i = 1'b0;
        tick();                       // second ACK cycle
        arst_n = 1'b0;
        #1;
        exp_crc  = 0;
        exp_drop = 0;
        check_idle_a("reset_mid_ack");
        check_cnts_a("reset_mid_ack_counters");
        tick();
        arst_n = 1'b1;
        tick();
        check_idle_a("reset_mid_ack_release");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_ack("ack");
        test_ack_ignored_idle();
        test_errors();
        test_busy_drop();
        test_boundary64();
        test_restart();
        test_cke();
        test_oversize_saturate();
        test_reset_mid_ack();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d frames still expected, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
